// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for the memory controller's single bus port.
// Each access runs IDLE -> ISSUE -> COMPLETE; DMA wins ties up to DMA_BURST_MAX in a row.
module mem_bus_arbiter #(
    parameter int DMA_BURST_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_pause,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        dma_pause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_pause
);
    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    localparam logic [7:0] BURST_MAX = 8'(DMA_BURST_MAX);

    state_t      state_q;
    logic        owner_dma_q;
    logic [7:0]  dma_run_q;
    logic        read_q;
    logic        cpu_done_q;
    logic        dma_done_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_size_q;
    logic        mem_write_q;

    logic grant_any;
    logic grant_dma;

    assign grant_any = ~mem_pause & (cpu_req | dma_req);
    assign grant_dma = dma_req & (~cpu_req | (dma_run_q != BURST_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_dma_q <= 1'b0;
            dma_run_q   <= 8'd0;
            read_q      <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_size_q  <= 2'd0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q     <= ISSUE;
                        owner_dma_q <= grant_dma;
                        if (grant_dma) begin
                            mem_addr_q  <= dma_addr;
                            mem_wdata_q <= dma_wdata;
                            mem_size_q  <= dma_size;
                            mem_write_q <= dma_write;
                            read_q      <= ~dma_write;
                        end else begin
                            mem_addr_q  <= cpu_addr;
                            mem_wdata_q <= cpu_wdata;
                            mem_size_q  <= cpu_size;
                            mem_write_q <= cpu_write;
                            read_q      <= ~cpu_write;
                        end
                        // Only a DMA grant that overtakes a waiting CPU extends the run.
                        if (grant_dma && cpu_req) begin
                            if (dma_run_q != BURST_MAX)
                                dma_run_q <= dma_run_q + 8'd1;
                        end else begin
                            dma_run_q <= 8'd0;
                        end
                    end
                end
                ISSUE: begin
                    state_q     <= COMPLETE;
                    mem_write_q <= 1'b0;
                    cpu_done_q  <= ~owner_dma_q;
                    dma_done_q  <= owner_dma_q;
                end
                default: begin
                    state_q     <= IDLE;
                    cpu_done_q  <= 1'b0;
                    dma_done_q  <= 1'b0;
                    mem_addr_q  <= 32'd0;
                    mem_wdata_q <= 32'd0;
                    mem_size_q  <= 2'd0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign mem_write = mem_write_q;

    assign cpu_done  = cpu_done_q;
    assign dma_done  = dma_done_q;
    // Controller read data lands in COMPLETE, one cycle after the address in ISSUE.
    assign cpu_rdata = (cpu_done_q && read_q) ? mem_rdata : 32'd0;
    assign dma_rdata = (dma_done_q && read_q) ? mem_rdata : 32'd0;
    assign cpu_pause = cpu_req & ~cpu_done_q;
    assign dma_pause = dma_req & ~dma_done_q;
endmodule
